// File: rtl/mode_sequencer.sv
// Front-panel mode selector: debounced forward/back buttons step a wrapping mode index.
// Define MODE_TIMEOUT_EN to add an idle auto-return to mode 0 (TIMEOUT_EVT pulse).

module mode_sequencer_btn #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [1:0]       vld;
    logic             level;
    logic             armed;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    assign flip = (sync[1] != level) && (cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            vld   <= '0;
            level <= 1'b0;
            armed <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync <= {sync[0], sw};
            vld  <= {vld[0], 1'b1};
            // A button held through reset must be seen released before it can press.
            if (vld[1] && !sync[1])
                armed <= 1'b1;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (flip) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            press <= flip & sync[1] & armed;
        end
    end
endmodule

module mode_sequencer #(
    parameter  int NUM_MODES       = 4,
    parameter  int DEBOUNCE_CYCLES = 4,
    parameter  int TIMEOUT_CYCLES  = 1000,
    localparam int IDX_W           = $clog2(NUM_MODES)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 SW_MODE,
    input  logic                 SW_BACK,
    input  logic                 LOCK,
    output logic [IDX_W-1:0]     MODE_IDX,
    output logic [NUM_MODES-1:0] MODE_RUN,
    output logic                 MODE_CHANGED,
    output logic                 TIMEOUT_EVT
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MODES - 1);
    localparam logic [IDX_W:0]   LAST_EXT = (IDX_W + 1)'(NUM_MODES - 1);

    logic             fwd;
    logic             back;
    logic             accepted;
    logic             illegal;
    logic [IDX_W-1:0] idx_next;
    logic             chg_next;
    logic             tmo_next;

    mode_sequencer_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fwd (
        .clk(CLK), .rst(RST), .sw(SW_MODE), .press(fwd)
    );
    mode_sequencer_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
        .clk(CLK), .rst(RST), .sw(SW_BACK), .press(back)
    );

    assign accepted = (fwd ^ back) & ~LOCK;
    assign illegal  = {1'b0, MODE_IDX} > LAST_EXT;

`ifdef MODE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;

    assign tmo_hit = (tmo_cnt == TMO_LAST) && !LOCK;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tmo_cnt     <= '0;
            TIMEOUT_EVT <= 1'b0;
        end else begin
            if (accepted || tmo_hit || LOCK || MODE_IDX == '0)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;
            TIMEOUT_EVT <= tmo_next;
        end
    end
`else
    assign TIMEOUT_EVT = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        idx_next = MODE_IDX;
        chg_next = 1'b0;
        tmo_next = 1'b0;
        if (illegal) begin
            idx_next = '0;
            chg_next = 1'b1;
        end else if (accepted) begin
            chg_next = 1'b1;
            if (fwd)
                idx_next = (MODE_IDX == LAST_IDX) ? '0 : MODE_IDX + 1'b1;
            else
                idx_next = (MODE_IDX == '0) ? LAST_IDX : MODE_IDX - 1'b1;
        end
`ifdef MODE_TIMEOUT_EN
        else if (tmo_hit) begin
            idx_next = '0;
            chg_next = 1'b1;
            tmo_next = 1'b1;
        end
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            MODE_IDX     <= '0;
            MODE_RUN     <= NUM_MODES'(1);
            MODE_CHANGED <= 1'b0;
        end else begin
            MODE_IDX     <= idx_next;
            MODE_RUN     <= NUM_MODES'(1) << idx_next;
            MODE_CHANGED <= chg_next;
        end
    end
endmodule
